// File: rtl/jtag_debug_ocimem_monitor.sv
// On-chip debug memory and monitor engine.
// Runs JTAG ocimem read/write commands against a private debug RAM and
// reports completion through MonDReg/monitor_ready/monitor_error. A CPU
// slave port shares the RAM; JTAG strobes take priority over it.
// Ports:
//   clk, reset_n             system clock, async active-low reset
//   jdo                      JTAG data-out register (sysclk domain)
//   take_action_ocimem_a     address/command load (+ optional read)
//   take_action_ocimem_b     write data phase
//   take_no_action_ocimem_a  host consumed MonDReg (autoinc read-ahead)
//   MonDReg, monitor_ready, monitor_error   results back to the wrapper
//   avs_*                    CPU word-addressed slave port with waitrequest
module jtag_debug_ocimem_monitor #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_J_RD    = 3'd1;
  localparam logic [2:0] S_J_WR    = 3'd2;
  localparam logic [2:0] S_CPU_RD  = 3'd3;
  localparam logic [2:0] S_CPU_ACK = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] mon_areg, mon_areg_nxt;
  logic              autoinc, autoinc_nxt;
  logic [DATA_W-1:0] wdata, wdata_nxt;
  logic [DATA_W-1:0] mon_dreg_nxt;
  logic              ready_nxt, error_nxt;
  logic [DATA_W-1:0] readdata_nxt;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [15:0]       addr_field;
  logic [ADDR_W-1:0] jdo_addr;
  logic              addr_oor;
  logic              any_strobe;
  logic              unused_jdo;

  assign addr_field = jdo[33:18];
  assign jdo_addr   = addr_field[ADDR_W-1:0];
  // Any address bit above the RAM depth makes the command illegal.
  assign addr_oor   = (addr_field >> ADDR_W) != 16'd0;
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign avs_waitrequest = (avs_read | avs_write) & (state != S_CPU_ACK);

  // Debug RAM: single port, contents not reset; read data is captured by
  // MonDReg / avs_readdata on the same edge, so no overlap is possible.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = mem[ram_addr];

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      mon_areg      <= '0;
      autoinc       <= 1'b0;
      wdata         <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      avs_readdata  <= '0;
    end else begin
      state         <= state_nxt;
      mon_areg      <= mon_areg_nxt;
      autoinc       <= autoinc_nxt;
      wdata         <= wdata_nxt;
      MonDReg       <= mon_dreg_nxt;
      monitor_ready <= ready_nxt;
      monitor_error <= error_nxt;
      avs_readdata  <= readdata_nxt;
    end
  end

  // Next-state, next-output and RAM control.
  always_comb begin
    state_nxt    = state;
    mon_areg_nxt = mon_areg;
    autoinc_nxt  = autoinc;
    wdata_nxt    = wdata;
    mon_dreg_nxt = MonDReg;
    ready_nxt    = monitor_ready;
    error_nxt    = monitor_error;
    readdata_nxt = avs_readdata;
    ram_addr     = mon_areg;
    ram_we       = 1'b0;
    ram_wdata    = wdata;

    case (state)
      S_IDLE: begin
        if (take_action_ocimem_b) begin
          ready_nxt = 1'b0;
          wdata_nxt = jdo[34:3];
          state_nxt = S_J_WR;
        end else if (take_action_ocimem_a) begin
          autoinc_nxt = jdo[34];
          ready_nxt   = 1'b0;
          error_nxt   = 1'b0;
          if (addr_oor) begin
            // Rejected: report at once, keep the current address.
            ready_nxt = 1'b1;
            error_nxt = 1'b1;
          end else begin
            mon_areg_nxt = jdo_addr;
            if (jdo[35]) begin
              state_nxt = S_J_RD;
            end else begin
              ready_nxt = 1'b1;
            end
          end
        end else if (take_no_action_ocimem_a) begin
          // Host consumed MonDReg: in autoinc mode prefetch the next word.
          if (autoinc) begin
            mon_areg_nxt = mon_areg + ADDR_W'(1);
            ready_nxt    = 1'b0;
            state_nxt    = S_J_RD;
          end
        end else if (avs_read) begin
          state_nxt = S_CPU_RD;
        end else if (avs_write) begin
          state_nxt = S_CPU_ACK;
        end
      end
      S_J_RD: begin
        mon_dreg_nxt = ram_rdata;
        ready_nxt    = 1'b1;
        state_nxt    = S_IDLE;
      end
      S_J_WR: begin
        ram_we    = 1'b1;
        ready_nxt = 1'b1;
        if (autoinc) begin
          mon_areg_nxt = mon_areg + ADDR_W'(1);
        end
        state_nxt = S_IDLE;
      end
      S_CPU_RD: begin
        ram_addr     = avs_address;
        readdata_nxt = ram_rdata;
        state_nxt    = S_CPU_ACK;
      end
      S_CPU_ACK: begin
        ram_addr  = avs_address;
        ram_we    = avs_write;
        ram_wdata = avs_writedata;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Strobes while busy are dropped but flagged; the current op finishes.
    if ((state != S_IDLE) && any_strobe) begin
      error_nxt = 1'b1;
    end
  end

endmodule
